// File: rtl/fetch_sequencer_if.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_if
//   Signal bundle between the fetch-stage control logic (fetch_sequencer) and
//   the surrounding pipeline: fetch PC register, decode hazard logic and the
//   IF/ID pipeline register.
//
//   Pipeline -> sequencer:
//     PC_Current     [7:0]  current value of the fetch PC register
//     Branch_Taken          taken branch/jump resolved this cycle
//     Branch_Target  [7:0]  redirect address, meaningful only with Branch_Taken
//     Stall                 load-use hazard from decode: hold fetch
//     Halt                  HALT decoded: stop fetching
//     Resume                leave the HALTED state
//   Sequencer -> pipeline:
//     PC_Next        [7:0]  next PC (combinational)
//     IFID_Enable           IF/ID load enable (combinational)
//     IFID_Flush            IF/ID clear-to-NOP (combinational)
//     Fetch_Valid           fetched instruction is live (combinational)
//     State          [1:0]  registered FSM state: 00 RUN, 01 STALL, 10 FLUSH, 11 HALTED
//     Branch_Count   [7:0]  saturating count of taken redirects
//     Stall_Count    [7:0]  saturating count of stalled cycles
//     Stall_Error           sticky stall-watchdog flag
//
//   Modports: master = pipeline side, slave = fetch_sequencer.
// -----------------------------------------------------------------------------
interface fetch_sequencer_if;
  logic [7:0] PC_Current;
  logic       Branch_Taken;
  logic [7:0] Branch_Target;
  logic       Stall;
  logic       Halt;
  logic       Resume;

  logic [7:0] PC_Next;
  logic       IFID_Enable;
  logic       IFID_Flush;
  logic       Fetch_Valid;
  logic [1:0] State;
  logic [7:0] Branch_Count;
  logic [7:0] Stall_Count;
  logic       Stall_Error;

  modport master (
    output PC_Current, Branch_Taken, Branch_Target, Stall, Halt, Resume,
    input  PC_Next, IFID_Enable, IFID_Flush, Fetch_Valid,
           State, Branch_Count, Stall_Count, Stall_Error
  );

  modport slave (
    input  PC_Current, Branch_Taken, Branch_Target, Stall, Halt, Resume,
    output PC_Next, IFID_Enable, IFID_Flush, Fetch_Valid,
           State, Branch_Count, Stall_Count, Stall_Error
  );
endinterface

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//   Next-PC controller for the instruction fetch stage of the 4-stage 8-bit
//   pipeline. Chooses between sequential fetch, taken-branch redirect,
//   load-use stall and HALT/resume, and drives the IF/ID register controls.
//   Also keeps saturating branch/stall event counters and a stall watchdog.
//
//   Ports:
//     Clk    rising-edge clock, shared with the fetch PC register
//     Reset  synchronous, active-high reset
//     bus    fetch_sequencer_if.slave (see interface file for members)
//
//   Parameters:
//     RESET_PC       PC driven on PC_Next while Reset is high
//     FLUSH_CYCLES   IFID_Flush cycles per redirect, redirect cycle included (1-4)
//     STALL_TIMEOUT  consecutive stalled cycles that set Stall_Error (2-255)
// -----------------------------------------------------------------------------
module fetch_sequencer #(
  parameter logic [7:0]  RESET_PC      = 8'h00,
  parameter int unsigned FLUSH_CYCLES  = 1,
  parameter int unsigned STALL_TIMEOUT = 16
) (
  input logic              Clk,
  input logic              Reset,
  fetch_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    STALL  = 2'b01,
    FLUSH  = 2'b10,
    HALTED = 2'b11
  } state_t;

  // The redirect cycle is the first flush cycle, so the counter only covers
  // the remaining FLUSH_CYCLES-1 bubbles.
  localparam logic [1:0] FLUSH_LOAD  = 2'(FLUSH_CYCLES - 1);
  localparam logic [7:0] STALL_LIMIT = 8'(STALL_TIMEOUT);
  localparam bit         USE_FLUSH   = (FLUSH_CYCLES > 1);

  state_t     state_q, state_d;
  logic [1:0] flush_cnt_q, flush_cnt_d;
  logic [7:0] stall_run_q, stall_run_d;
  logic [7:0] branch_count_q;
  logic [7:0] stall_count_q;
  logic       stall_error_q;

  logic [7:0] pc_inc;
  logic [7:0] pc_next;
  logic       ifid_enable;
  logic       ifid_flush;
  logic       fetch_valid;
  logic       branch_event;
  logic       stall_event;

  assign pc_inc = bus.PC_Current + 8'd1;  // 8-bit wrap, FF -> 00

  // NOTE: every signal written here gets a default first; a path that skips
  // an assignment would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    flush_cnt_d  = flush_cnt_q;
    stall_run_d  = stall_run_q;
    pc_next      = pc_inc;
    ifid_enable  = 1'b1;
    ifid_flush   = 1'b0;
    fetch_valid  = 1'b0;
    branch_event = 1'b0;
    stall_event  = 1'b0;

    case (state_q)
      RUN, STALL: begin
        if (bus.Branch_Taken) begin
          pc_next      = bus.Branch_Target;
          ifid_flush   = 1'b1;
          branch_event = 1'b1;
          flush_cnt_d  = FLUSH_LOAD;
          stall_run_d  = 8'd0;
          state_d      = USE_FLUSH ? FLUSH : RUN;
        end else if (bus.Halt) begin
          pc_next     = bus.PC_Current;
          ifid_enable = 1'b0;
          stall_run_d = 8'd0;
          state_d     = HALTED;
        end else if (bus.Stall) begin
          pc_next     = bus.PC_Current;
          ifid_enable = 1'b0;
          stall_event = 1'b1;
          stall_run_d = (stall_run_q == 8'hFF) ? stall_run_q : stall_run_q + 8'd1;
          state_d     = STALL;
        end else begin
          fetch_valid = 1'b1;
          stall_run_d = 8'd0;
          state_d     = RUN;
        end
      end

      FLUSH: begin
        // Stall/Halt are ignored: the slot being fetched is already a bubble.
        ifid_flush = 1'b1;
        if (bus.Branch_Taken) begin
          pc_next      = bus.Branch_Target;
          branch_event = 1'b1;
          flush_cnt_d  = FLUSH_LOAD;
          state_d      = USE_FLUSH ? FLUSH : RUN;
        end else begin
          flush_cnt_d = flush_cnt_q - 2'd1;
          if (flush_cnt_q <= 2'd1) begin
            flush_cnt_d = 2'd0;
            state_d     = RUN;
          end
        end
      end

      HALTED: begin
        // PC stays frozen in the Resume cycle too; fetch restarts one later.
        pc_next     = bus.PC_Current;
        ifid_enable = 1'b0;
        if (bus.Resume) state_d = RUN;
      end

      default: state_d = RUN;
    endcase

    // Reset overrides the combinational controls so the pipeline sees a
    // flushed IF/ID and the PC register loads RESET_PC at the same edge.
    if (Reset) begin
      pc_next     = RESET_PC;
      ifid_enable = 1'b1;
      ifid_flush  = 1'b1;
      fetch_valid = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q        <= RUN;
      flush_cnt_q    <= 2'd0;
      stall_run_q    <= 8'd0;
      branch_count_q <= 8'd0;
      stall_count_q  <= 8'd0;
      stall_error_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      stall_run_q <= stall_run_d;
      if (branch_event && branch_count_q != 8'hFF)
        branch_count_q <= branch_count_q + 8'd1;
      if (stall_event && stall_count_q != 8'hFF)
        stall_count_q <= stall_count_q + 8'd1;
      if (stall_event && stall_run_d >= STALL_LIMIT)
        stall_error_q <= 1'b1;
    end
  end

  assign bus.PC_Next      = pc_next;
  assign bus.IFID_Enable  = ifid_enable;
  assign bus.IFID_Flush   = ifid_flush;
  assign bus.Fetch_Valid  = fetch_valid;
  assign bus.State        = state_q;
  assign bus.Branch_Count = branch_count_q;
  assign bus.Stall_Count  = stall_count_q;
  assign bus.Stall_Error  = stall_error_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//   Directed bench for fetch_sequencer (FLUSH_CYCLES=2, STALL_TIMEOUT=16).
//   The bench plays the fetch PC register by driving PC_Current with
//   hand-computed values; combinational outputs are checked 1 ns after the
//   inputs settle, registered outputs 1 ns after the clock edge.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

  logic Clk = 1'b0;
  logic Reset;
  int   vectors = 0;
  int   miscompares = 0;

  localparam logic [1:0] S_RUN = 2'b00, S_STALL = 2'b01, S_FLUSH = 2'b10, S_HALTED = 2'b11;

  fetch_sequencer_if bus ();

  fetch_sequencer #(
    .RESET_PC      (8'h00),
    .FLUSH_CYCLES  (2),
    .STALL_TIMEOUT (16)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [7:0] pc, input logic br, input logic [7:0] tgt,
                       input logic st, input logic hl, input logic rs);
    bus.PC_Current    = pc;
    bus.Branch_Taken  = br;
    bus.Branch_Target = tgt;
    bus.Stall         = st;
    bus.Halt          = hl;
    bus.Resume        = rs;
    #1;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Check the four combinational controls in one go.
  task automatic check_ctl(input string tag, input logic [7:0] pc, input logic en,
                           input logic fl, input logic vld);
    check({tag, ".pc"},    {24'd0, bus.PC_Next},     {24'd0, pc});
    check({tag, ".en"},    {31'd0, bus.IFID_Enable}, {31'd0, en});
    check({tag, ".flush"}, {31'd0, bus.IFID_Flush},  {31'd0, fl});
    check({tag, ".valid"}, {31'd0, bus.Fetch_Valid}, {31'd0, vld});
  endtask

  initial begin
    Reset = 1'b1;
    drive(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    drive(8'h37, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check_ctl("reset", 8'h00, 1'b1, 1'b1, 1'b0);
    check("reset.state", {30'd0, bus.State}, {30'd0, S_RUN});
    check("reset.bcnt",  {24'd0, bus.Branch_Count}, 32'd0);
    check("reset.scnt",  {24'd0, bus.Stall_Count}, 32'd0);
    check("reset.err",   {31'd0, bus.Stall_Error}, 32'd0);
    tick();
    Reset = 1'b0;

    // Sequential fetch from 00; Branch_Target held at X to prove no leakage.
    for (int i = 0; i < 5; i++) begin
      drive(8'(i), 1'b0, 8'hxx, 1'b0, 1'b0, 1'b0);
      check_ctl($sformatf("seq%0d", i), 8'(i + 1), 1'b1, 1'b0, 1'b1);
      tick();
      check($sformatf("seq%0d.state", i), {30'd0, bus.State}, {30'd0, S_RUN});
    end

    drive(8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check_ctl("wrap", 8'h00, 1'b1, 1'b0, 1'b1);
    tick();

    // Redirect to 40 at PC 10: two flush cycles, then RUN at 42.
    drive(8'h10, 1'b1, 8'h40, 1'b0, 1'b0, 1'b0);
    check_ctl("br", 8'h40, 1'b1, 1'b1, 1'b0);
    tick();
    check("br.state", {30'd0, bus.State}, {30'd0, S_FLUSH});
    check("br.bcnt",  {24'd0, bus.Branch_Count}, 32'd1);
    drive(8'h40, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check_ctl("br.flush2", 8'h41, 1'b1, 1'b1, 1'b0);
    tick();
    check("br.run", {30'd0, bus.State}, {30'd0, S_RUN});
    drive(8'h41, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check_ctl("br.after", 8'h42, 1'b1, 1'b0, 1'b1);
    tick();

    // Stall at PC 20: held PC, count stalls, watchdog fires on the 16th cycle.
    for (int i = 1; i <= 16; i++) begin
      drive(8'h20, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      if (i <= 3) check_ctl($sformatf("stall%0d", i), 8'h20, 1'b0, 1'b0, 1'b0);
      tick();
      if (i == 3) begin
        check("stall3.state", {30'd0, bus.State}, {30'd0, S_STALL});
        check("stall3.scnt",  {24'd0, bus.Stall_Count}, 32'd3);
      end
      if (i == 15) check("stall15.err", {31'd0, bus.Stall_Error}, 32'd0);
    end
    check("stall16.err",  {31'd0, bus.Stall_Error}, 32'd1);
    check("stall16.scnt", {24'd0, bus.Stall_Count}, 32'd16);
    drive(8'h20, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check_ctl("unstall", 8'h21, 1'b1, 1'b0, 1'b1);
    tick();
    check("unstall.err",   {31'd0, bus.Stall_Error}, 32'd1);
    check("unstall.state", {30'd0, bus.State}, {30'd0, S_RUN});

    // Halt at 30, ignored branch, then resume.
    drive(8'h30, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check_ctl("halt", 8'h30, 1'b0, 1'b0, 1'b0);
    tick();
    check("halt.state", {30'd0, bus.State}, {30'd0, S_HALTED});
    drive(8'h30, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    check_ctl("halt.br", 8'h30, 1'b0, 1'b0, 1'b0);
    tick();
    check("halt.br.state", {30'd0, bus.State}, {30'd0, S_HALTED});
    check("halt.br.bcnt",  {24'd0, bus.Branch_Count}, 32'd1);
    drive(8'h30, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check_ctl("resume", 8'h30, 1'b0, 1'b0, 1'b0);
    tick();
    check("resume.state", {30'd0, bus.State}, {30'd0, S_RUN});
    drive(8'h30, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check_ctl("resume.next", 8'h31, 1'b1, 1'b0, 1'b1);
    tick();

    // Branch, Stall and Halt together: redirect wins.
    drive(8'h50, 1'b1, 8'h80, 1'b1, 1'b1, 1'b0);
    check_ctl("prio", 8'h80, 1'b1, 1'b1, 1'b0);
    tick();
    check("prio.state", {30'd0, bus.State}, {30'd0, S_FLUSH});
    check("prio.bcnt",  {24'd0, bus.Branch_Count}, 32'd2);
    check("prio.scnt",  {24'd0, bus.Stall_Count}, 32'd16);

    // Reset in FLUSH clears everything.
    Reset = 1'b1;
    drive(8'h80, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check_ctl("rstflush", 8'h00, 1'b1, 1'b1, 1'b0);
    tick();
    Reset = 1'b0;
    check("rstflush.state", {30'd0, bus.State}, {30'd0, S_RUN});
    check("rstflush.bcnt",  {24'd0, bus.Branch_Count}, 32'd0);
    check("rstflush.scnt",  {24'd0, bus.Stall_Count}, 32'd0);
    check("rstflush.err",   {31'd0, bus.Stall_Error}, 32'd0);
    drive(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check_ctl("rstflush.run", 8'h01, 1'b1, 1'b0, 1'b1);
    tick();

    // Redirect inside FLUSH reloads; Stall during FLUSH is ignored.
    drive(8'h60, 1'b1, 8'h70, 1'b0, 1'b0, 1'b0);
    tick();
    drive(8'h70, 1'b1, 8'h90, 1'b0, 1'b0, 1'b0);
    check_ctl("rebr", 8'h90, 1'b1, 1'b1, 1'b0);
    tick();
    check("rebr.state", {30'd0, bus.State}, {30'd0, S_FLUSH});
    check("rebr.bcnt",  {24'd0, bus.Branch_Count}, 32'd2);
    drive(8'h90, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check_ctl("flushstall", 8'h91, 1'b1, 1'b1, 1'b0);
    tick();
    check("flushstall.state", {30'd0, bus.State}, {30'd0, S_RUN});
    check("flushstall.scnt",  {24'd0, bus.Stall_Count}, 32'd0);

    // Stall counter saturation.
    for (int i = 0; i < 260; i++) begin
      drive(8'h91, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      tick();
    end
    check("sat.scnt", {24'd0, bus.Stall_Count}, 32'hFF);
    check("sat.err",  {31'd0, bus.Stall_Error}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Next-PC controller for the instruction fetch stage of the 4-stage 8-bit pipeline.
- Drives the fetch PC register's next-PC input and the IF/ID pipeline register's enable and flush controls.
- Arbitrates sequential fetch, taken-branch redirect, load-use stall and HALT/resume.
- Keeps saturating branch and stall event counters and a stall watchdog for debug.

Parameters:
- RESET_PC, 8'h00, PC value driven on PC_Next while Reset is high.
- FLUSH_CYCLES, 1, cycles IFID_Flush is asserted per redirect, including the redirect cycle; legal range 1-4.
- STALL_TIMEOUT, 16, consecutive stalled cycles that set Stall_Error; legal range 2-255.

Ports:
- Clk  input  1  rising-edge clock, shared with the fetch PC register.
- Reset  input  1  synchronous, active-high reset.
- PC_Current  input  8  current value of the fetch PC register.
- Branch_Taken  input  1  taken branch/jump resolved this cycle.
- Branch_Target  input  8  redirect address; valid when Branch_Taken=1.
- Stall  input  1  load-use hazard request from decode: hold fetch.
- Halt  input  1  HALT decoded: stop fetching.
- Resume  input  1  leave HALTED.
- PC_Next  output  8  next PC, combinational; loaded by the fetch PC register at the next edge.
- IFID_Enable  output  1  IF/ID register load enable, combinational.
- IFID_Flush  output  1  IF/ID register clear to NOP, combinational.
- Fetch_Valid  output  1  fetched instruction is live, i.e. not stalled, halted or flushed; combinational.
- State  output  2  registered FSM state: 00 RUN, 01 STALL, 10 FLUSH, 11 HALTED.
- Branch_Count  output  8  registered; taken redirects, saturates at 8'hFF.
- Stall_Count  output  8  registered; stalled cycles, saturates at 8'hFF.
- Stall_Error  output  1  registered, sticky watchdog flag.

Behaviour:
- Reset, sampled at the edge:
  - Registered values: State=RUN, flush counter=0, consecutive-stall counter=0, Branch_Count=0, Stall_Count=0, Stall_Error=0.
  - Combinational outputs while Reset=1: PC_Next=RESET_PC, IFID_Enable=1, IFID_Flush=1, Fetch_Valid=0.
  - Reset mid-FLUSH, STALL or HALTED aborts the operation with no residue.
- Priority per cycle, highest first: Reset > Branch_Taken > Halt > Stall > sequential.
- PC increment: PC_Current+1, 8-bit modulo, so 8'hFF wraps to 8'h00 with no flag.
- RUN / STALL, Branch_Taken=1:
  - PC_Next=Branch_Target, IFID_Flush=1, IFID_Enable=1, Fetch_Valid=0.
  - Branch_Count increments.
  - Flush counter loads FLUSH_CYCLES-1.
  - Next state is FLUSH if FLUSH_CYCLES>1, else RUN.
- RUN / STALL, Halt=1 (no branch):
  - PC_Next=PC_Current, IFID_Enable=0, Fetch_Valid=0.
  - Next state HALTED.
- RUN / STALL, Stall=1 (no branch or halt):
  - PC_Next=PC_Current, IFID_Enable=0, IFID_Flush=0, Fetch_Valid=0.
  - Next state STALL; Stall_Count increments; consecutive-stall counter increments.
  - When the consecutive-stall counter reaches STALL_TIMEOUT, Stall_Error is set and held until Reset.
- RUN / STALL, no request:
  - PC_Next=PC_Current+1, IFID_Enable=1, IFID_Flush=0, Fetch_Valid=1.
  - Next state RUN; consecutive-stall counter clears.
- FLUSH:
  - PC_Next=PC_Current+1, IFID_Flush=1, IFID_Enable=1, Fetch_Valid=0.
  - Flush counter decrements; returns to RUN in the cycle the counter reads 1.
  - Stall and Halt are ignored in FLUSH because the slot is a bubble.
  - Branch_Taken in FLUSH redirects again and reloads the counter, with Branch_Count incrementing.
- HALTED:
  - PC_Next=PC_Current, IFID_Enable=0, IFID_Flush=0, Fetch_Valid=0.
  - Branch_Taken, Stall and Halt are ignored.
  - Resume=1 sets next state RUN; PC is still held in the Resume cycle, and sequential fetch restarts the following cycle.
- Counters saturate at 8'hFF and never wrap.
- Outputs are undefined-free: no X propagation from Branch_Target when Branch_Taken=0.

Test Plan:
- Reset then 5 idle cycles from PC=8'h00 -> PC_Next sequence 01,02,03,04,05; Fetch_Valid=1; State=00.
- PC_Current=8'hFF, no request -> PC_Next=8'h00.
- Branch_Taken=1 with target 8'h40 at PC=8'h10, FLUSH_CYCLES=2 -> PC_Next=40 and IFID_Flush=1 for 2 cycles, then RUN with PC_Next=42; Branch_Count=1.
- Stall high for 3 cycles at PC=8'h20 -> PC_Next=20 held, IFID_Enable=0, Stall_Count=3; run with Stall held to 16 cycles -> Stall_Error=1, still 1 after Stall drops.
- Halt at PC=8'h30, then Branch_Taken pulse, then Resume -> PC held at 30 throughout; branch ignored; State 11->00; next cycle PC_Next=31.
- Branch_Taken and Stall and Halt in the same cycle -> redirect wins; Reset asserted in FLUSH -> State=00, counters 0, PC_Next=RESET_PC.
